button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Upstream input stage for the alarm controller. Conditions the three raw
//  active-low push buttons (start/stop, set, snooze). Each button is
//  synchronised, debounced and edge-detected. Per button the block gives:
//   - a clean active-low level,
//   - a one-cycle press pulse,
//   - a one-cycle release pulse.
//  Buttons selected in REPEAT_MASK also auto-repeat while held, so the user
//  can hold the set button to step the timer up quickly.
// PARAMETERS
//  NUM_BTN          3     number of button channels (bit0 start_stop, bit1 set, bit2 snooze)
//  DEBOUNCE_CYCLES  16    cycles the synced input must differ from the stable level before it flips; >=2
//  HOLD_CYCLES      200   cycles from the press pulse to the first auto-repeat pulse; >=1
//  REPEAT_CYCLES    50    cycles between successive auto-repeat pulses; >=1
//  REPEAT_MASK      3'b010 per-channel auto-repeat enable (default: set button only)
// PORTS
//  CLK          in   1        system clock; all logic on posedge
//  RST_N        in   1        asynchronous active-low reset
//  btn_raw_n    in   NUM_BTN  raw pins, asynchronous, active low (0 = pressed)
//  btn_level_n  out  NUM_BTN  debounced level, active low; feeds controller button inputs
//  btn_press    out  NUM_BTN  1-cycle pulse on debounced press or auto-repeat
//  btn_repeat   out  NUM_BTN  1-cycle pulse, asserted only together with an auto-repeat btn_press
//  btn_release  out  NUM_BTN  1-cycle pulse on debounced release
// BEHAVIOUR
//  Reset (async assert, sync use after deassert):
//   - sync FFs, btn_level_n = all 1 (released)
//   - btn_press, btn_repeat, btn_release = 0
//   - all counters = 0
//  Channels are fully independent. Any combination of bits may pulse in the same cycle.
//  Sync: 2-FF chain per channel, reset to 1. s = second stage output.
//  Debounce counter dcnt, width $clog2(DEBOUNCE_CYCLES). Per edge:
//   - s == level:                   dcnt <= 0.
//   - s != level, dcnt < D-1:       dcnt <= dcnt+1.
//   - s != level, dcnt == D-1:      level <= s, dcnt <= 0, and assert the edge pulse
//     (press if new level 0, release if 1).
//  Latency: input held low before sampling edge E0 -> level falls and press pulses
//   after edge E0+D+1 (D+2 edges in total). Release has the same latency.
//  Glitch rejection:
//   - a bounce shorter than D synced cycles produces no output;
//   - any return to the stable level restarts the count from 0.
//  Pulses are registered, high for exactly one cycle, and aligned with the level change.
//  Auto-repeat per channel, only where REPEAT_MASK[i]=1. FSM:
//   - IDLE:  level released. On debounced press -> HOLD, rcnt <= 0.
//   - HOLD:  rcnt counts; at rcnt == HOLD_CYCLES-1 -> pulse press+repeat, rcnt <= 0, go to RPT.
//   - RPT:   at rcnt == REPEAT_CYCLES-1 -> pulse press+repeat, rcnt <= 0, stay in RPT.
//   - Debounced release in any state -> IDLE, rcnt <= 0. The release pulse still fires;
//     no repeat pulse fires on the release cycle.
//  Channels with mask 0: FSM held in IDLE; btn_repeat is constant 0.
//  rcnt width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)). No wrap: rcnt is cleared at each terminal count.
//  Reset mid-operation: all state returns to released/IDLE. No pulses fire during or on exit from reset.
//   If a button is held through reset, a normal press occurs D+2 edges after RST_N rises.
//  Invalid parameters (D<2, HOLD or REPEAT <1) are caught by an elaboration-time check
//   ($error in generate).
// STRUCTURE
//  Shared package alarm_pkg:
//   - button index constants BTN_START_STOP=0, BTN_SET=1, BTN_SNOOZE=2;
//   - repeat-FSM state localparams IDLE/HOLD/RPT (2-bit encoding).
//  One sub-module, debounce_channel: sync + debounce + edge pulses + repeat FSM for a single
//   button, with a REPEAT_EN parameter.
//  Top level: generate loop of NUM_BTN debounce_channel instances. No other logic.
// TESTING (bench: D=4, HOLD=20, REPEAT=8, CLK 10 ns)
//  1. Reset: btn_raw_n=3'b111, RST_N low then high.
//     -> btn_level_n=3'b111, all pulses 0 for 50 cycles.
//  2. Clean press: hold btn_raw_n[0]=0 from edge E0.
//     -> btn_level_n[0]=0 and btn_press[0] high exactly 1 cycle after edge E0+5.
//     Release: btn_release[0] 1 cycle, with the same latency.
//  3. Bounce on bit 2: toggle 0/1 every 2 cycles for 20 cycles, then hold 0.
//     -> no pulse during the bounce; a single press 6 edges after the final settle.
//  4. Auto-repeat: hold set (bit1) low for 70 cycles after the press pulse.
//     -> repeat pulses (press+repeat) at +20, +28, +36, +44, +52, +60, +68.
//     Then release -> btn_release[1], no further press.
//  5. Mask off: hold bit0 for 70 cycles -> exactly one btn_press[0]; btn_repeat[0] stays 0.
//  6. Simultaneous, then reset: press bits 0 and 2 on the same edge -> both press pulses in the same cycle.
//     Assert RST_N mid-hold -> level=111 at once, no release pulse.
//     After RST_N rises -> new presses 6 edges later.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller front end: button indices,
// auto-repeat FSM encoding and a counter-width helper.
package alarm_pkg;

    localparam int unsigned BTN_START_STOP = 0;
    localparam int unsigned BTN_SET        = 1;
    localparam int unsigned BTN_SNOOZE     = 2;

    // Auto-repeat FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } rpt_state_e;

    // Width of a counter reaching n-1; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce counter, registered
// press/release pulses and an optional hold-to-repeat FSM.
module debounce_channel
    import alarm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 200,
    parameter int unsigned REPEAT_CYCLES   = 50,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw_n,
    output logic level_n,
    output logic press,
    output logic rpt,
    output logic rel
);

    localparam int unsigned DW    = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned RMAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RW    = cnt_width(RMAX);
    localparam logic [DW-1:0] DTOP = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] HTOP = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RTOP = RW'(REPEAT_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    rpt_state_e    state_q, state_d;
    logic          press_q, rpt_q, rel_q;
    logic          fall, rise, auto;
    logic          s;

    assign s = sync_q[1];

    // Synchroniser, debounce and repeat state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            state_q <= IDLE;
            press_q <= 1'b0;
            rpt_q   <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_n};
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            state_q <= state_d;
            press_q <= fall | auto;
            rpt_q   <= auto;
            rel_q   <= rise;
        end
    end

    // Debounce: flip the level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        level_d = level_q;
        dcnt_d  = dcnt_q;
        fall    = 1'b0;
        rise    = 1'b0;
        if (s == level_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DTOP) begin
            level_d = s;
            dcnt_d  = '0;
            fall    = ~s;
            rise    = s;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    // Auto-repeat FSM; a release wins over a coincident repeat terminal count
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        auto    = 1'b0;
        if (!REPEAT_EN) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else if (rise) begin
            state_d = IDLE;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rcnt_d = '0;
                    if (fall) state_d = HOLD;
                end
                HOLD: begin
                    if (rcnt_q == HTOP) begin
                        auto    = 1'b1;
                        rcnt_d  = '0;
                        state_d = RPT;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                RPT: begin
                    if (rcnt_q == RTOP) begin
                        auto   = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                end
            endcase
        end
    end

    assign level_n = level_q;
    assign press   = press_q;
    assign rpt     = rpt_q;
    assign rel     = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Input stage for the alarm controller: one independent debounce channel per
// active-low push button.
module button_conditioner
    import alarm_pkg::*;
#(
    parameter int unsigned        NUM_BTN         = 3,
    parameter int unsigned        DEBOUNCE_CYCLES = 16,
    parameter int unsigned        HOLD_CYCLES     = 200,
    parameter int unsigned        REPEAT_CYCLES   = 50,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 3'b010
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_BTN-1:0] btn_raw_n,
    output logic [NUM_BTN-1:0] btn_level_n,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic [NUM_BTN-1:0] btn_release
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("button_conditioner: HOLD_CYCLES must be >= 1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .raw_n   (btn_raw_n[i]),
            .level_n (btn_level_n[i]),
            .press   (btn_press[i]),
            .rpt     (btn_repeat[i]),
            .rel     (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with D=4, HOLD=20, REPEAT=8.
module tb_button_conditioner;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] raw_n = 3'b111;
    logic [2:0] level_n, press, rpt, rel;

    int tests = 0;
    int fails = 0;

    button_conditioner #(
        .NUM_BTN         (3),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R),
        .REPEAT_MASK     (3'b010)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .btn_raw_n   (raw_n),
        .btn_level_n (level_n),
        .btn_press   (press),
        .btn_repeat  (rpt),
        .btn_release (rel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] raw;
        int         edges;
        logic [2:0] lvl;
        logic [2:0] prs;
        logic [2:0] rp;
        logic [2:0] rl;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [2:0] l, input logic [2:0] p,
                             input logic [2:0] r, input logic [2:0] rl);
        check(name, {level_n, press, rpt, rel}, {l, p, r, rl});
    endtask

    initial begin
        int npress, nrpt, nrel;
        logic exp;

        // Clean press/release on bit 0, edge E0 is the first edge after the change
        vecs[0] = '{raw: 3'b111, edges: 1, lvl: 3'b111, prs: 3'b000, rp: 3'b000, rl: 3'b000};
        vecs[1] = '{raw: 3'b110, edges: 5, lvl: 3'b111, prs: 3'b000, rp: 3'b000, rl: 3'b000};
        vecs[2] = '{raw: 3'b110, edges: 1, lvl: 3'b110, prs: 3'b001, rp: 3'b000, rl: 3'b000};
        vecs[3] = '{raw: 3'b110, edges: 1, lvl: 3'b110, prs: 3'b000, rp: 3'b000, rl: 3'b000};
        vecs[4] = '{raw: 3'b111, edges: 5, lvl: 3'b110, prs: 3'b000, rp: 3'b000, rl: 3'b000};
        vecs[5] = '{raw: 3'b111, edges: 1, lvl: 3'b111, prs: 3'b000, rp: 3'b000, rl: 3'b001};
        vecs[6] = '{raw: 3'b111, edges: 1, lvl: 3'b111, prs: 3'b000, rp: 3'b000, rl: 3'b000};
        // Three-sample glitch on bit 0 is shorter than D synced cycles
        vecs[7] = '{raw: 3'b111, edges: 8, lvl: 3'b111, prs: 3'b000, rp: 3'b000, rl: 3'b000};

        // 1. Reset
        step(3);
        check_all("in_reset", 3'b111, 3'b000, 3'b000, 3'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            check_all("after_reset", 3'b111, 3'b000, 3'b000, 3'b000);
        end

        // 2. Table-driven clean press / release
        for (int i = 0; i < 7; i++) begin
            raw_n = vecs[i].raw;
            step(vecs[i].edges);
            check_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs, vecs[i].rp, vecs[i].rl);
        end
        raw_n = 3'b110;
        step(3);
        raw_n = vecs[7].raw;
        step(vecs[7].edges);
        check_all("vec7_glitch", vecs[7].lvl, vecs[7].prs, vecs[7].rp, vecs[7].rl);

        // 3. Bounce on bit 2, then settle low
        npress = 0;
        nrel   = 0;
        for (int i = 0; i < 10; i++) begin
            raw_n[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < 2; k++) begin
                step(1);
                npress += int'(press[2]);
                nrel   += int'(rel[2]);
            end
        end
        raw_n[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            npress += int'(press[2]);
            nrel   += int'(rel[2]);
        end
        check("bounce_no_pulse", {npress, nrel}, 0);
        check("bounce_level_before", level_n[2], 1'b1);
        step(1);
        check_all("bounce_press", 3'b011, 3'b100, 3'b000, 3'b000);
        npress = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            npress += int'(press[2]);
        end
        check("bounce_single_press", npress, 0);
        raw_n[2] = 1'b1;
        step(6);
        check_all("bounce_release", 3'b111, 3'b000, 3'b000, 3'b100);
        step(4);

        // 4. Auto-repeat on set
        raw_n = 3'b101;
        step(6);
        check_all("set_press", 3'b101, 3'b010, 3'b000, 3'b000);
        for (int k = 1; k <= 70; k++) begin
            step(1);
            exp = (k >= H) && ((k - H) % R == 0);
            check($sformatf("repeat_k%0d", k), {press[1], rpt[1], rel[1]}, {exp, exp, 1'b0});
        end
        raw_n = 3'b111;
        // Release lands at k=76, which is also a repeat terminal count
        npress = 0;
        nrel   = 0;
        for (int k = 71; k <= 80; k++) begin
            step(1);
            npress += int'(press[1]) + int'(rpt[1]);
            if (k == 76) check("set_release_pulse", rel[1], 1'b1);
            else nrel += int'(rel[1]);
        end
        check("set_no_press_after_release", npress, 0);
        check("set_single_release", nrel, 0);
        check("set_level_released", level_n, 3'b111);

        // 5. Mask off: bit 0 held does not repeat
        raw_n = 3'b110;
        step(6);
        check_all("mask_press", 3'b110, 3'b001, 3'b000, 3'b000);
        npress = 0;
        nrpt   = 0;
        for (int k = 0; k < 70; k++) begin
            step(1);
            npress += int'(press[0]);
            nrpt   += int'(rpt[0]);
        end
        check("mask_no_extra_press", npress, 0);
        check("mask_no_repeat", nrpt, 0);
        raw_n = 3'b111;
        step(6);
        check_all("mask_release", 3'b111, 3'b000, 3'b000, 3'b001);
        step(4);

        // 6. Simultaneous press on bits 0 and 2, then reset mid-hold
        raw_n = 3'b010;
        step(6);
        check_all("simul_press", 3'b010, 3'b101, 3'b000, 3'b000);
        step(10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("reset_mid_hold", 3'b111, 3'b000, 3'b000, 3'b000);
        nrel = 0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            nrel += int'(rel != 3'b000) + int'(press != 3'b000);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            nrel += int'(rel != 3'b000) + int'(press != 3'b000) + int'(level_n != 3'b111);
        end
        check("reset_quiet", nrel, 0);
        step(1);
        check_all("press_after_reset", 3'b010, 3'b101, 3'b000, 3'b000);
        raw_n = 3'b111;
        step(6);
        check_all("final_release", 3'b111, 3'b000, 3'b000, 3'b101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
